vga_timing_detect: RTL

VGA_TIMING_DETECT -- requirements
Module: vga_timing_detect

---
 rtl/vga_timing_detect.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_detect.sv
// VGA timing detector: measures line/frame totals and active extents from de/hsync/vsync,
// publishes them once per frame and reports lock once identical measurements repeat.
module vga_timing_detect #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  output logic             de_o,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             meas_valid,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CntMax      = {CNT_W{1'b1}};
  localparam int unsigned      StabW       = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
  // A run of LOCK_FRAMES identical measurements contains LOCK_FRAMES-1 matches.
  localparam logic [StabW-1:0] LockMatches = StabW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CntMax)) ? v + CNT_W'(1) : v;
  endfunction

  logic de_r, hs_r, vs_r, de_q, hs_q, vs_q;
  logic hs_fall, vs_fall, de_fall;

  logic [CNT_W-1:0] lc_q, lc_d, ac_q, ac_d, vl_q, vl_d, va_q, va_d;
  logic [CNT_W-1:0] line_total_q, line_total_d, line_active_q, line_active_d;
  logic [CNT_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [CNT_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic [CNT_W-1:0] v_total_new, v_active_new;
  logic             meas_valid_q, meas_match, timing_lost;
  logic [StabW-1:0] stab_q, stab_d;
  state_e           state_q, state_d;

  always_comb begin
    hs_fall = hs_q & ~hs_r;
    vs_fall = vs_q & ~vs_r;
    de_fall = de_q & ~de_r;

    lc_d          = hs_fall ? '0 : sat_inc(lc_q, 1'b1);
    line_total_d  = hs_fall ? sat_inc(lc_q, 1'b1) : line_total_q;
    ac_d          = de_fall ? '0 : sat_inc(ac_q, de_r);
    line_active_d = de_fall ? ac_q : line_active_q;

    // Edges coinciding with vsync fall belong to the frame being closed.
    v_total_new  = sat_inc(vl_q, hs_fall);
    v_active_new = sat_inc(va_q, de_fall);
    vl_d         = vs_fall ? '0 : v_total_new;
    va_d         = vs_fall ? '0 : v_active_new;

    // The line closed by a coincident hsync fall is the last line of the frame.
    h_total_d  = vs_fall ? line_total_d  : h_total_q;
    h_active_d = vs_fall ? line_active_d : h_active_q;
    v_total_d  = vs_fall ? v_total_new   : v_total_q;
    v_active_d = vs_fall ? v_active_new  : v_active_q;

    meas_match = (line_total_d == h_total_q) && (line_active_d == h_active_q) &&
                 (v_total_new == v_total_q) && (v_active_new == v_active_q);
    timing_lost = (lc_q == CntMax) || (vl_q == CntMax);
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    if (timing_lost) begin
      state_d = StSearch;
      stab_d  = '0;
    end else if (vs_fall) begin
      unique case (state_q)
        StSearch: begin
          state_d = StTrack;
          stab_d  = '0;
        end
        StTrack, StLocked: begin
          if (meas_match) begin
            if (stab_q != LockMatches) stab_d = stab_q + StabW'(1);
            if (stab_d == LockMatches) state_d = StLocked;
          end else begin
            stab_d  = '0;
            state_d = StTrack;
          end
        end
        default: begin
          state_d = StSearch;
          stab_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_r          <= 1'b0;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      de_q          <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      lc_q          <= '0;
      ac_q          <= '0;
      vl_q          <= '0;
      va_q          <= '0;
      line_total_q  <= '0;
      line_active_q <= '0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      meas_valid_q  <= 1'b0;
      stab_q        <= '0;
      state_q       <= StSearch;
    end else begin
      de_r          <= de;
      hs_r          <= hsync;
      vs_r          <= vsync;
      de_q          <= de_r;
      hs_q          <= hs_r;
      vs_q          <= vs_r;
      lc_q          <= lc_d;
      ac_q          <= ac_d;
      vl_q          <= vl_d;
      va_q          <= va_d;
      line_total_q  <= line_total_d;
      line_active_q <= line_active_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
      meas_valid_q  <= vs_fall;
      stab_q        <= stab_d;
      state_q       <= state_d;
    end
  end

  assign de_o       = de_r;
  assign pix_x      = ac_q;
  assign pix_y      = va_q;
  assign h_total    = h_total_q;
  assign h_active   = h_active_q;
  assign v_total    = v_total_q;
  assign v_active   = v_active_q;
  assign meas_valid = meas_valid_q;
  assign locked     = (state_q == StLocked);

endmodule
